// File: rtl/ex_lsu.sv
// Execute stage for an RV64 pipeline: a combinational ALU plus a single-outstanding
// load/store unit that freezes the upstream stages until the data bus acks.
module ex_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] alu_op_num1_i,
    input  logic [63:0] alu_op_num2_i,
    input  logic [63:0] data_rs2_i,
    input  logic [4:0]  addr_rd_i,
    input  logic        reg_wr_en_i,
    input  logic [2:0]  alu_operation_i,
    input  logic        alu_add_sub_i,
    input  logic        alu_shift_i,
    input  logic        word_intercept_i,
    input  logic [2:0]  load_code_i,
    input  logic [2:0]  store_code_i,
    output logic        hold_n_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [63:0] mem_rdata_i,
    output logic [63:0] wb_data_o,
    output logic [4:0]  wb_addr_rd_o,
    output logic        wb_wr_en_o
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;
    localparam logic [2:0]  NOPE = 3'b111;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic              req_d, we_d;
    logic [XLEN-1:0]   addr_d, wdata_d;
    logic [7:0]        wstrb_d;
    logic [2:0]        ld_code_q, ld_code_d;
    logic [XLEN-1:0]   wb_data_d;
    logic [4:0]        wb_addr_d;
    logic              wb_wr_en_d;

    // ALU datapath, word variants computed on the low 32 bits and sign-extended
    logic [XLEN-1:0] sum, sll_d, srl_d, sra_d, alu_c;
    logic [WLEN-1:0] sum_w, sll_w, srl_w, sra_w, sr_w;

    assign sum   = alu_add_sub_i ? alu_op_num1_i - alu_op_num2_i : alu_op_num1_i + alu_op_num2_i;
    assign sum_w = alu_add_sub_i ? alu_op_num1_i[31:0] - alu_op_num2_i[31:0]
                                 : alu_op_num1_i[31:0] + alu_op_num2_i[31:0];
    assign sll_d = alu_op_num1_i << alu_op_num2_i[5:0];
    assign srl_d = alu_op_num1_i >> alu_op_num2_i[5:0];
    assign sra_d = $signed(alu_op_num1_i) >>> alu_op_num2_i[5:0];
    assign sll_w = alu_op_num1_i[31:0] << alu_op_num2_i[4:0];
    assign srl_w = alu_op_num1_i[31:0] >> alu_op_num2_i[4:0];
    assign sra_w = $signed(alu_op_num1_i[31:0]) >>> alu_op_num2_i[4:0];
    assign sr_w  = alu_shift_i ? sra_w : srl_w;

    always_comb begin
        alu_c = '0;
        unique case (alu_operation_i)
            3'b000: alu_c = word_intercept_i ? {{WLEN{sum_w[31]}}, sum_w} : sum;
            3'b001: alu_c = word_intercept_i ? {{WLEN{sll_w[31]}}, sll_w} : sll_d;
            3'b010: alu_c = {63'b0, $signed(alu_op_num1_i) < $signed(alu_op_num2_i)};
            3'b011: alu_c = {63'b0, alu_op_num1_i < alu_op_num2_i};
            3'b100: alu_c = alu_op_num1_i ^ alu_op_num2_i;
            3'b101: alu_c = word_intercept_i ? {{WLEN{sr_w[31]}}, sr_w}
                                             : (alu_shift_i ? sra_d : srl_d);
            3'b110: alu_c = alu_op_num1_i | alu_op_num2_i;
            3'b111: alu_c = alu_op_num1_i & alu_op_num2_i;
            default: alu_c = '0;
        endcase
    end

    // Memory request formation; a load beats a simultaneous store
    logic            is_load, mem_op;
    logic [1:0]      size;
    logic [7:0]      size_mask, strobe;
    logic [XLEN-1:0] ea, wdata_sh;

    assign is_load  = load_code_i != NOPE;
    assign mem_op   = is_load || (store_code_i != NOPE);
    assign ea       = alu_op_num1_i + alu_op_num2_i;
    assign size     = is_load ? load_code_i[1:0] : store_code_i[1:0];
    assign strobe   = size_mask << ea[2:0];
    assign wdata_sh = data_rs2_i << {ea[2:0], 3'b000};

    always_comb begin
        size_mask = 8'h00;
        unique case (size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
            default: size_mask = 8'h00;
        endcase
    end

    // Lane-align returned data and extend according to the captured load code
    logic [XLEN-1:0] rd_sh, ld_data;
    assign rd_sh = mem_rdata_i >> {mem_addr_o[2:0], 3'b000};

    always_comb begin
        ld_data = rd_sh;
        unique case (ld_code_q)
            3'b000: ld_data = {{56{rd_sh[7]}},  rd_sh[7:0]};
            3'b001: ld_data = {{48{rd_sh[15]}}, rd_sh[15:0]};
            3'b010: ld_data = {{32{rd_sh[31]}}, rd_sh[31:0]};
            3'b100: ld_data = {56'b0, rd_sh[7:0]};
            3'b101: ld_data = {48'b0, rd_sh[15:0]};
            3'b110: ld_data = {32'b0, rd_sh[31:0]};
            default: ld_data = rd_sh;
        endcase
    end

    assign hold_n_o = !(((state_q == IDLE) && mem_op) || ((state_q == BUSY) && !mem_ack_i));

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        req_d      = mem_req_o;
        we_d       = mem_we_o;
        addr_d     = mem_addr_o;
        wdata_d    = mem_wdata_o;
        wstrb_d    = mem_wstrb_o;
        ld_code_d  = ld_code_q;
        wb_data_d  = '0;
        wb_addr_d  = '0;
        wb_wr_en_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d   = BUSY;
                    req_d     = 1'b1;
                    we_d      = !is_load;
                    addr_d    = ea;
                    wdata_d   = wdata_sh;
                    wstrb_d   = is_load ? 8'h00 : strobe;
                    ld_code_d = load_code_i;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (hold_n_o) begin
            wb_addr_d  = addr_rd_i;
            wb_wr_en_d = reg_wr_en_i;
            wb_data_d  = ((state_q == BUSY) && (ld_code_q != NOPE)) ? ld_data : alu_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_wstrb_o  <= '0;
            ld_code_q    <= NOPE;
            wb_data_o    <= '0;
            wb_addr_rd_o <= '0;
            wb_wr_en_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_o    <= req_d;
            mem_we_o     <= we_d;
            mem_addr_o   <= addr_d;
            mem_wdata_o  <= wdata_d;
            mem_wstrb_o  <= wstrb_d;
            ld_code_q    <= ld_code_d;
            wb_data_o    <= wb_data_d;
            wb_addr_rd_o <= wb_addr_d;
            wb_wr_en_o   <= wb_wr_en_d;
        end
    end

endmodule

// File: tb/tb_ex_lsu.sv
// Directed bench for ex_lsu: inputs change on the falling edge, outputs are checked there too.
module tb_ex_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] num1, num2, rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [2:0]  op;
    logic        add_sub, shift, word;
    logic [2:0]  ld_code, st_code;
    logic        hold_n;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] NOPE = 3'b111;

    ex_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .alu_op_num1_i(num1), .alu_op_num2_i(num2), .data_rs2_i(rs2),
        .addr_rd_i(rd), .reg_wr_en_i(wen),
        .alu_operation_i(op), .alu_add_sub_i(add_sub), .alu_shift_i(shift),
        .word_intercept_i(word),
        .load_code_i(ld_code), .store_code_i(st_code),
        .hold_n_o(hold_n),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .wb_data_o(wb_data), .wb_addr_rd_o(wb_rd), .wb_wr_en_o(wb_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_alu(input logic [2:0] o, input logic as, input logic sh, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] d, input logic e);
        op = o; add_sub = as; shift = sh; word = w;
        num1 = a; num2 = b; rd = d; wen = e;
        ld_code = NOPE; st_code = NOPE;
    endtask

    task automatic set_mem(input logic [2:0] lc, input logic [2:0] sc,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] d2,
                           input logic [4:0] d, input logic e);
        set_alu(3'b000, 1'b0, 1'b0, 1'b0, a, b, d, e);
        ld_code = lc; st_code = sc; rs2 = d2;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu_case(input string tag, input logic [2:0] o, input logic as, input logic sh,
                            input logic w, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp);
        set_alu(o, as, sh, w, a, b, 5'd9, 1'b1);
        #1 chk({tag, "_hold"}, 64'(hold_n), 64'd1);
        step();
        chk(tag, wb_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; rs2 = '0;
        set_alu(3'b000, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_addr",  mem_addr, 64'd0);
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_wb",    wb_data, 64'd0);
        chk("rst_wen",   64'(wb_wen), 64'd0);
        chk("rst_hold",  64'(hold_n), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU vectors
        set_alu(3'b000, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF, 64'd1, 5'd5, 1'b1);
        step();
        chk("addw_data", wb_data, 64'd0);
        chk("addw_rd",   64'(wb_rd), 64'd5);
        chk("addw_wen",  64'(wb_wen), 64'd1);
        alu_case("add",   3'b000, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'h1_0000_0000);
        alu_case("sra",   3'b101, 1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        alu_case("sraw",  3'b101, 1'b0, 1'b1, 1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        alu_case("srlw",  3'b101, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000);
        alu_case("srl",   3'b101, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
        alu_case("sub",   3'b000, 1'b1, 1'b0, 1'b0, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        alu_case("subw",  3'b000, 1'b1, 1'b0, 1'b1, 64'h1_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_case("sll63", 3'b001, 1'b0, 1'b0, 1'b0, 64'd1, 64'h7F, 64'h8000_0000_0000_0000);
        alu_case("sllw",  3'b001, 1'b0, 1'b0, 1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000);
        alu_case("slt",   3'b010, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        alu_case("sltu",  3'b011, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        alu_case("xorw",  3'b100, 1'b0, 1'b0, 1'b1, 64'hF0F0_0000_0000_00FF, 64'h0F00_0000_0000_0F0F, 64'hFFF0_0000_0000_0FF0);
        alu_case("or",    3'b110, 1'b0, 1'b0, 1'b0, 64'h1200, 64'h0034, 64'h1234);
        alu_case("and",   3'b111, 1'b0, 1'b0, 1'b0, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'h0F00_0F00);

        // LB with ack two cycles after the request appears
        set_mem(3'b000, NOPE, 64'h1000, 64'd3, 64'd0, 5'd7, 1'b1);
        #1 chk("lb_hold0", 64'(hold_n), 64'd0);
        step();
        chk("lb_req",   64'(mem_req), 64'd1);
        chk("lb_addr",  mem_addr, 64'h1003);
        chk("lb_we",    64'(mem_we), 64'd0);
        chk("lb_wstrb", 64'(mem_wstrb), 64'd0);
        chk("lb_hold1", 64'(hold_n), 64'd0);
        chk("lb_bub1",  64'(wb_wen), 64'd0);
        step();
        chk("lb_hold2", 64'(hold_n), 64'd0);
        chk("lb_bub2",  64'(wb_wen), 64'd0);
        chk("lb_req2",  64'(mem_req), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h0000_0000_8000_0000;
        #1 chk("lb_hold3", 64'(hold_n), 64'd1);
        step();
        mem_ack = 1'b0;
        chk("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rd",   64'(wb_rd), 64'd7);
        chk("lb_wen",  64'(wb_wen), 64'd1);
        chk("lb_reqd", 64'(mem_req), 64'd0);

        // SH at ea 0x2006
        set_mem(NOPE, 3'b001, 64'h2000, 64'd6, 64'hABCD, 5'd0, 1'b0);
        step();
        chk("sh_we",    64'(mem_we), 64'd1);
        chk("sh_wstrb", 64'(mem_wstrb), 64'hC0);
        chk("sh_wdata", mem_wdata, 64'hABCD_0000_0000_0000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sh_wen", 64'(wb_wen), 64'd0);
        chk("sh_req", 64'(mem_req), 64'd0);

        // SW crossing the 8-byte boundary: upper lanes are dropped
        set_mem(NOPE, 3'b010, 64'h3000, 64'd6, 64'h1122_3344, 5'd0, 1'b0);
        step();
        chk("sw_wstrb", 64'(mem_wstrb), 64'hC0);
        chk("sw_wdata", mem_wdata, 64'h3344_0000_0000_0000);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;

        // Load and store together: the load wins
        set_mem(3'b011, 3'b011, 64'h4000, 64'd0, 64'hDEAD, 5'd3, 1'b1);
        step();
        chk("ldst_we",    64'(mem_we), 64'd0);
        chk("ldst_wstrb", 64'(mem_wstrb), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        mem_ack = 1'b0;
        chk("ld_data", wb_data, 64'h0123_4567_89AB_CDEF);

        // Back-to-back loads with ack held high: one request each
        mem_ack = 1'b1;
        mem_rdata = 64'h8765_4321_0000_0000;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_mem(3'b010, NOPE, 64'h5000, 64'd4, 64'd0, 5'd10, 1'b1);
                1: set_mem(3'b110, NOPE, 64'h5000, 64'd4, 64'd0, 5'd11, 1'b1);
                default: set_mem(3'b101, NOPE, 64'h5000, 64'd6, 64'd0, 5'd12, 1'b1);
            endcase
            #1 chk("b2b_idle_req", 64'(mem_req), 64'd0);
            step();
            chk("b2b_req",  64'(mem_req), 64'd1);
            chk("b2b_hold", 64'(hold_n), 64'd1);
            step();
            chk("b2b_reqd", 64'(mem_req), 64'd0);
            case (i)
                0: chk("b2b_lw",  wb_data, 64'hFFFF_FFFF_8765_4321);
                1: chk("b2b_lwu", wb_data, 64'h0000_0000_8765_4321);
                default: chk("b2b_lhu", wb_data, 64'h0000_0000_0000_8765);
            endcase
            chk("b2b_rd", 64'(wb_rd), 64'(10 + i));
        end
        mem_ack = 1'b0;
        set_alu(3'b000, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        step();

        // Reset while BUSY, then a late ack
        set_mem(3'b011, NOPE, 64'h6000, 64'd0, 64'd0, 5'd4, 1'b1);
        step();
        chk("rb_req_pre", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rb_req",  64'(mem_req), 64'd0);
        chk("rb_addr", mem_addr, 64'd0);
        chk("rb_wb",   wb_data, 64'd0);
        chk("rb_wen",  64'(wb_wen), 64'd0);
        set_alu(3'b000, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        #1 chk("rb_hold", 64'(hold_n), 64'd1);
        step();
        mem_ack = 1'b0;
        chk("rb_late_req", 64'(mem_req), 64'd0);
        chk("rb_late_wen", 64'(wb_wen), 64'd0);
        alu_case("rb_alu", 3'b000, 1'b0, 1'b0, 1'b0, 64'd40, 64'd2, 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_lsu.md
EX_LSU -- requirements
Module: ex_lsu

Interface
REQ-001 SHALL have these ports, clock and reset first: clk  in  1  single clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL take these decoded operand inputs from the ID/EX register: alu_op_num1_i / alu_op_num2_i  in  64  ALU operands; data_rs2_i  in  64  store data; addr_rd_i  in  5  destination register; reg_wr_en_i  in  1  writeback enable.
REQ-003 SHALL take these control inputs: alu_operation_i  in  3  ADD=000 SLL=001 SLT=010 SLTU=011 XOR=100 SR=101 OR=110 AND=111; alu_add_sub_i  in  1  0 add / 1 sub; alu_shift_i  in  1  0 logical / 1 arithmetic right; word_intercept_i  in  1  RV64 W-op.
REQ-004 SHALL take these memory-op codes: load_code_i  in  3  LB=000 LH=001 LW=010 LD=011 LBU=100 LHU=101 LWU=110 NOPE=111; store_code_i  in  3  SB=000 SH=001 SW=010 SD=011 NOPE=111.
REQ-005 SHALL drive hold_n_o  out  1, which feeds the ID/EX hold_n input; 0 = freeze upstream.
REQ-006 SHALL have this data-memory bus: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  64; mem_wdata_o  out  64; mem_wstrb_o  out  8; mem_ack_i  in  1; mem_rdata_i  in  64.
REQ-007 SHALL drive these writeback outputs: wb_data_o  out  64; wb_addr_rd_o  out  5; wb_wr_en_o  out  1.

Function
REQ-008 ALU result SHALL be combinational: ADD/SUB per alu_add_sub_i; shifts use num2[5:0] (num2[4:0] if word); SLT signed, SLTU unsigned, result 0/1.
REQ-009 When word_intercept_i=1, ADD/SUB/SLL/SR SHALL operate on num1[31:0], and the 32-bit result SHALL be sign-extended to 64 bits; for other ops word_intercept_i SHALL be ignored.
REQ-010 A memory op SHALL be any cycle with load_code_i!=NOPE or store_code_i!=NOPE; if both are non-NOPE, the load SHALL win and the store SHALL be ignored.
REQ-011 Effective address ea SHALL be num1+num2 (64-bit, wrap-around), not word-intercepted.
REQ-012 FSM states SHALL be IDLE and BUSY; transitions SHALL be IDLE->BUSY on a memory op; BUSY->IDLE on mem_ack_i=1; otherwise the FSM SHALL hold its state.
REQ-013 On IDLE->BUSY the block SHALL register mem_req_o=1, mem_addr_o=ea, mem_we_o=store, mem_wstrb_o=(size mask 1/3/F/FF)<<ea[2:0] truncated to 8 bits (0x00 for loads), and mem_wdata_o=data_rs2_i<<(8*ea[2:0]).
REQ-014 mem_req_o/addr/we/wstrb/wdata SHALL stay stable in BUSY until the ack edge, then mem_req_o SHALL drop to 0 on that same edge.
REQ-015 mem_ack_i SHALL be ignored while mem_req_o=0; a single-cycle ack SHALL suffice.
REQ-016 hold_n_o SHALL = !((IDLE and memory op) or (BUSY and !mem_ack_i)), combinational.
REQ-017 On every edge with hold_n_o=1 the writeback registers SHALL load wb_addr_rd_o=addr_rd_i, wb_wr_en_o=reg_wr_en_i, and wb_data_o=ALU result, or the load data for a completing load.
REQ-018 Load data SHALL be mem_rdata_i>>(8*mem_addr_o[2:0]), then sign- or zero-extended per load code.
REQ-019 On every edge with hold_n_o=0 the writeback registers SHALL load a bubble: wb_wr_en_o=0, wb_addr_rd_o=0, wb_data_o=0.
REQ-020 ALU-op latency SHALL be 1 cycle; memory-op latency SHALL be 1 + cycles to ack (minimum 2).
REQ-021 Accesses crossing an 8-byte boundary SHALL NOT be split; lanes shifted past bit 63 or strobe bit 7 SHALL be dropped.

Reset
REQ-022 On rst_n=0 the block SHALL asynchronously enter IDLE and drive mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, wb_data_o=0, wb_addr_rd_o=0, wb_wr_en_o=0.
REQ-023 Reset asserted in BUSY SHALL abandon the transaction; a late mem_ack_i after reset SHALL be ignored per REQ-015.
REQ-024 After rst_n deasserts, hold_n_o SHALL depend only on current inputs.

Verification
REQ-025 ALU: num1=0xFFFFFFFF, num2=1, ADD, word=1, rd=5, wr_en=1 -> next cycle wb_data_o=0, wb_addr_rd_o=5, wb_wr_en_o=1; word=0 -> 0x100000000.
REQ-026 SR arithmetic: num1=0x8000000000000000, num2=4, shift=1 -> 0xF800000000000000; word=1 with num1=0x80000000 -> 0xFFFFFFFFF8000000.
REQ-027 LB: num1=0x1000, num2=3, rdata=0x00000000_80000000 with ack 2 cycles after req -> hold_n_o low 3 cycles, bubbles meanwhile, then wb_data_o=0xFFFFFFFFFFFFFF80.
REQ-028 SH: ea=0x2006, rs2=0xABCD -> mem_we_o=1, mem_wstrb_o=0xC0, mem_wdata_o=0xABCD000000000000, wb_wr_en_o=0 (decoder) on completion.
REQ-029 Ack held high continuously, back-to-back loads -> each load issues exactly one req, and no duplicate request occurs.
REQ-030 rst_n pulsed low in BUSY, then ack arrives -> mem_req_o=0 immediately, state IDLE, wb outputs 0, ack ignored.
